// File: rtl/soc_mode_pkg.sv
// Shared types and constants for the board-level mode/reset sequencer.
package soc_mode_pkg;

    // Sequencer states; encodings are visible on the debug state output.
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2,
        ST_PROG   = 2'd3
    } mode_state_e;

    // Level of an idle UART RX line.
    localparam logic RX_IDLE = 1'b1;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a bus of independent asynchronous bits.
module bit_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two back-to-back capture stages; the first may go metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/soc_mode_ctrl.sv
// Board-level mode and reset sequencer: debounces the programmer-mode pin,
// sequences core/programmer resets so they are never released together, and
// routes synchronised UART RX lines. Optional break-based mode entry is
// compiled in with the macro SOC_MODE_CTRL_BREAK_ENTRY_EN.
module soc_mode_ctrl
    import soc_mode_pkg::*;
#(
    parameter int NUM_UART          = 2,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int RESET_HOLD_CYCLES = 32,
    parameter int BREAK_CYCLES      = 1000000
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                prog_mode_i,
    input  logic [NUM_UART-1:0] uart_rx_i,
    output logic [NUM_UART-1:0] core_uart_rx_o,
    output logic                prog_rx_o,
    output logic                core_reset_no,
    output logic                prog_reset_no,
    output logic                prog_enable_o,
    output logic [1:0]          state_o
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [DEB_W-1:0]    DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_MAX  = HOLD_W'(RESET_HOLD_CYCLES);
    localparam logic [NUM_UART-1:0] ALL_CH    = {NUM_UART{1'b1}};
    // In PROG channel 0 belongs to the programmer, the rest stay with the core.
    localparam logic [NUM_UART-1:0] PROG_CORE_CH = ~(NUM_UART'(1'b1));

    if (NUM_UART < 1 || DEBOUNCE_CYCLES < 1 || RESET_HOLD_CYCLES < 1 || BREAK_CYCLES < 1) begin : g_bad_cfg
        $error("soc_mode_ctrl: all size parameters must be at least 1");
    end

    logic                mode_sync_s;
    logic [NUM_UART-1:0] rx_sync_s;
    logic                mode_prev_r;
    logic [DEB_W-1:0]    deb_cnt_r;
    logic [DEB_W-1:0]    deb_cnt_s;
    logic                mode_stable_r;
    logic                break_latch_s;
    logic                eff_mode_s;
    mode_state_e         state_r;
    mode_state_e         next_state_s;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic                core_reset_r;
    logic                prog_reset_r;
    logic                prog_en_r;
    logic [NUM_UART-1:0] core_rx_en_r;
    logic                prog_rx_en_r;

    bit_sync #(.WIDTH(1), .RESET_VAL(1'b0)) u_mode_sync (
        .clk   (clk_i),
        .rst_n (reset_ni),
        .d     (prog_mode_i),
        .q     (mode_sync_s)
    );

    bit_sync #(.WIDTH(NUM_UART), .RESET_VAL({NUM_UART{RX_IDLE}})) u_rx_sync (
        .clk   (clk_i),
        .rst_n (reset_ni),
        .d     (uart_rx_i),
        .q     (rx_sync_s)
    );

    // Length of the current run of equal synchronised mode values, capped.
    always_comb begin
        deb_cnt_s = deb_cnt_r;
        if (mode_sync_s != mode_prev_r) begin
            deb_cnt_s = DEB_W'(1);
        end else if (deb_cnt_r != DEB_MAX) begin
            deb_cnt_s = deb_cnt_r + DEB_W'(1);
        end else begin
            deb_cnt_s = deb_cnt_r;
        end
    end

    // Debounce registers: accept the mode once the run is long enough.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mode_prev_r   <= 1'b0;
            deb_cnt_r     <= '0;
            mode_stable_r <= 1'b0;
        end else begin
            mode_prev_r <= mode_sync_s;
            deb_cnt_r   <= deb_cnt_s;
            if (deb_cnt_s == DEB_MAX) begin
                mode_stable_r <= mode_sync_s;
            end else begin
                mode_stable_r <= mode_stable_r;
            end
        end
    end

`ifdef SOC_MODE_CTRL_BREAK_ENTRY_EN
    localparam int BRK_W = $clog2(BREAK_CYCLES + 1);
    localparam logic [BRK_W-1:0] BRK_MAX = BRK_W'(BREAK_CYCLES);

    logic [BRK_W-1:0] brk_cnt_r;
    logic [BRK_W-1:0] brk_cnt_s;
    logic             brk_hit_s;
    logic             break_latch_r;

    // Count low cycles on ch0 while an agent runs; one-shot hit at the limit.
    always_comb begin
        brk_cnt_s = brk_cnt_r;
        brk_hit_s = 1'b0;
        if (state_r == ST_BOOT || state_r == ST_SWITCH) begin
            brk_cnt_s = '0;
        end else if (rx_sync_s[0] == RX_IDLE) begin
            brk_cnt_s = '0;
        end else if (brk_cnt_r != BRK_MAX) begin
            brk_cnt_s = brk_cnt_r + BRK_W'(1);
            brk_hit_s = (brk_cnt_r == BRK_MAX - BRK_W'(1));
        end else begin
            brk_cnt_s = brk_cnt_r;
        end
    end

    // Break counter and latch: a break in RUN requests PROG, in PROG releases it.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            brk_cnt_r     <= '0;
            break_latch_r <= 1'b0;
        end else begin
            brk_cnt_r <= brk_cnt_s;
            if (brk_hit_s && state_r == ST_RUN) begin
                break_latch_r <= 1'b1;
            end else if (brk_hit_s && state_r == ST_PROG) begin
                break_latch_r <= 1'b0;
            end else begin
                break_latch_r <= break_latch_r;
            end
        end
    end

    assign break_latch_s = break_latch_r;
`else
    assign break_latch_s = 1'b0;
`endif

    assign eff_mode_s = mode_stable_r | break_latch_s;

    // Next-state logic; hold states sample the target mode only at exit.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_BOOT, ST_SWITCH: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    next_state_s = eff_mode_s ? ST_PROG : ST_RUN;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_RUN: begin
                if (eff_mode_s) begin
                    next_state_s = ST_SWITCH;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_PROG: begin
                if (!eff_mode_s) begin
                    next_state_s = ST_SWITCH;
                end else begin
                    next_state_s = ST_PROG;
                end
            end
            default: next_state_s = ST_BOOT;
        endcase
    end

    // State register and saturating hold counter cleared on every state entry.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r    <= ST_BOOT;
            hold_cnt_r <= '0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s != state_r) begin
                hold_cnt_r <= '0;
            end else if (hold_cnt_r != HOLD_MAX) begin
                hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
        end
    end

    // Output registers decoded from the next state so they change with state_r.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            core_reset_r <= 1'b0;
            prog_reset_r <= 1'b0;
            prog_en_r    <= 1'b0;
            core_rx_en_r <= '0;
            prog_rx_en_r <= 1'b0;
        end else begin
            case (next_state_s)
                ST_RUN: begin
                    core_reset_r <= 1'b1;
                    prog_reset_r <= 1'b0;
                    prog_en_r    <= 1'b0;
                    core_rx_en_r <= ALL_CH;
                    prog_rx_en_r <= 1'b0;
                end
                ST_PROG: begin
                    core_reset_r <= 1'b0;
                    prog_reset_r <= 1'b1;
                    prog_en_r    <= 1'b1;
                    core_rx_en_r <= PROG_CORE_CH;
                    prog_rx_en_r <= 1'b1;
                end
                ST_SWITCH: begin
                    core_reset_r <= 1'b0;
                    prog_reset_r <= 1'b0;
                    prog_en_r    <= prog_en_r;
                    core_rx_en_r <= '0;
                    prog_rx_en_r <= 1'b0;
                end
                default: begin
                    core_reset_r <= 1'b0;
                    prog_reset_r <= 1'b0;
                    prog_en_r    <= 1'b0;
                    core_rx_en_r <= '0;
                    prog_rx_en_r <= 1'b0;
                end
            endcase
        end
    end

    // Disabled RX paths idle high; enabled ones carry the synchroniser output.
    assign core_uart_rx_o = (rx_sync_s & core_rx_en_r) | ({NUM_UART{RX_IDLE}} & ~core_rx_en_r);
    assign prog_rx_o      = prog_rx_en_r ? rx_sync_s[0] : RX_IDLE;
    assign core_reset_no  = core_reset_r;
    assign prog_reset_no  = prog_reset_r;
    assign prog_enable_o  = prog_en_r;
    assign state_o        = state_r;

endmodule

// File: tb/tb_soc_mode_ctrl.sv
// Randomised self-checking bench for soc_mode_ctrl against a behavioural model.
module tb_soc_mode_ctrl;

    localparam int NU   = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int BRK  = 20;
    localparam int S_BOOT = 0, S_RUN = 1, S_SWITCH = 2, S_PROG = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pin = 1'b0;
    logic [NU-1:0] rx = '1;
    logic [NU-1:0] core_rx;
    logic          prog_rx, core_rst_n, prog_rst_n, prog_en;
    logic [1:0]    state;

    soc_mode_ctrl #(
        .NUM_UART(NU), .DEBOUNCE_CYCLES(DEB),
        .RESET_HOLD_CYCLES(HOLD), .BREAK_CYCLES(BRK)
    ) dut (
        .clk_i(clk), .reset_ni(reset_n), .prog_mode_i(pin), .uart_rx_i(rx),
        .core_uart_rx_o(core_rx), .prog_rx_o(prog_rx),
        .core_reset_no(core_rst_n), .prog_reset_no(prog_rst_n),
        .prog_enable_o(prog_en), .state_o(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pin/RX sample history (index 0 = newest edge sample)
    int            m_state, m_cyc, m_brk;
    bit            m_stable, m_pen, m_latch;
    bit            pin_q[$];
    logic [NU-1:0] rx_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        pin_q.delete();
        rx_q.delete();
        repeat (DEB + 2) pin_q.push_back(1'b0);
        repeat (3) rx_q.push_back('1);
        m_state = S_BOOT; m_cyc = 1; m_brk = 0;
        m_stable = 1'b0; m_pen = 1'b0; m_latch = 1'b0;
    endfunction

    // One rising edge: p/r are the pad values sampled at this edge.
    function automatic void model_edge(bit p, logic [NU-1:0] r);
        int nxt;
        bit eff, all_eq;
        eff = m_stable | m_latch;
        nxt = m_state;
        case (m_state)
            S_BOOT, S_SWITCH: if (m_cyc == HOLD) nxt = eff ? S_PROG : S_RUN;
            S_RUN:            if (eff) nxt = S_SWITCH;
            S_PROG:           if (!eff) nxt = S_SWITCH;
            default:          nxt = S_BOOT;
        endcase
        // synchronised mode of the last DEB cycles = pin samples of edges n-2 .. n-DEB-1
        all_eq = 1'b1;
        for (int i = 2; i <= DEB; i++) if (pin_q[i] != pin_q[1]) all_eq = 1'b0;
        if (all_eq) m_stable = pin_q[1];
`ifdef SOC_MODE_CTRL_BREAK_ENTRY_EN
        if ((m_state == S_RUN || m_state == S_PROG) && rx_q[1][0] == 1'b0) begin
            if (m_brk < BRK) begin
                m_brk++;
                if (m_brk == BRK) m_latch = (m_state == S_RUN);
            end
        end else begin
            m_brk = 0;
        end
`endif
        if (nxt != m_state) m_cyc = 1; else m_cyc++;
        m_state = nxt;
        if (m_state == S_RUN) m_pen = 1'b0;
        else if (m_state == S_PROG) m_pen = 1'b1;
        else if (m_state == S_BOOT) m_pen = 1'b0;
        pin_q.push_front(p); void'(pin_q.pop_back());
        rx_q.push_front(r);  void'(rx_q.pop_back());
    endfunction

    task automatic check_all();
        logic [NU-1:0] exp_core;
        logic          exp_prog;
        exp_core = (m_state == S_RUN)  ? rx_q[1] :
                   (m_state == S_PROG) ? (rx_q[1] | NU'(1)) : '1;
        exp_prog = (m_state == S_PROG) ? rx_q[1][0] : 1'b1;
        check("state",      32'(state),      32'(m_state));
        check("core_rst_n", 32'(core_rst_n), 32'(m_state == S_RUN));
        check("prog_rst_n", 32'(prog_rst_n), 32'(m_state == S_PROG));
        check("prog_en",    32'(prog_en),    32'(m_pen));
        check("core_rx",    32'(core_rx),    32'(exp_core));
        check("prog_rx",    32'(prog_rx),    32'(exp_prog));
        check("rst_excl",   32'(core_rst_n & prog_rst_n), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(pin, rx);
        #1;
        check_all();
    endtask

    task automatic step_rand_rx(input int n);
        for (int i = 0; i < n; i++) begin
            rx = NU'($urandom);
            step();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_state(input int target, input int budget, output int n);
        n = 0;
        while (32'(state) != 32'(target) && n < budget) begin
            step();
            n++;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int run_left;
        bit saw_run;

        pin = 1'b0; rx = '1;
        do_reset();
        check("reset_core_rx", 32'(core_rx), 32'(2'b11));

        // Boot: 8 cycles in BOOT, then RUN
        wait_state(S_RUN, 50, n);
        check("boot_len", 32'(n), 32'd8);
        check("run_core_rst", 32'(core_rst_n), 32'd1);
        step_rand_rx(10);

        // 3-cycle glitch on the pin is ignored
        rx = '1;
        pin = 1'b1; repeat (3) step();
        pin = 1'b0; repeat (12) step();
        check("glitch_state", 32'(state), 32'(S_RUN));

        // Held pin: SWITCH after 2+4+1 cycles, PROG after 8 more
        pin = 1'b1;
        wait_state(S_SWITCH, 50, n);
        check("switch_lat", 32'(n), 32'd7);
        wait_state(S_PROG, 50, n);
        check("switch_len", 32'(n), 32'd8);
        check("prog_en_prog", 32'(prog_en), 32'd1);
        step_rand_rx(20);

        // Drop the pin, re-raise early in SWITCH: must land back in PROG
        pin = 1'b0;
        wait_state(S_SWITCH, 50, n);
        check("switch_lat_down", 32'(n), 32'd7);
        step();
        pin = 1'b1;
        saw_run = 1'b0;
        for (int i = 0; i < 30; i++) begin
            rx = NU'($urandom);
            step();
            if (state == 2'(S_RUN)) saw_run = 1'b1;
        end
        check("no_run_on_bounce", 32'(saw_run), 32'd0);
        check("bounce_prog", 32'(state), 32'(S_PROG));

        // Asynchronous reset in PROG takes effect within the cycle
        @(posedge clk);
        model_edge(pin, rx);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_state", 32'(state), 32'd0);
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Random pin runs and random RX against the model
        run_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                pin = ~pin;
                run_left = $urandom_range(1, 40);
            end
            run_left--;
            rx = NU'($urandom);
            step();
            if (i % 1500 == 1499) do_reset();
        end

`ifdef SOC_MODE_CTRL_BREAK_ENTRY_EN
        // Break entry: 20 low cycles on ch0 in RUN go to PROG, again in PROG back to RUN
        pin = 1'b0; rx = '1;
        do_reset();
        wait_state(S_RUN, 50, n);
        rx = 2'b10;
        wait_state(S_SWITCH, 60, n);
        check("brk_enter_lat", 32'(n), 32'd23);
        rx = '1;
        wait_state(S_PROG, 50, n);
        check("brk_prog", 32'(state), 32'(S_PROG));
        rx = 2'b10;
        wait_state(S_SWITCH, 60, n);
        check("brk_exit_lat", 32'(n), 32'd23);
        rx = '1;
        wait_state(S_RUN, 50, n);
        check("brk_run", 32'(state), 32'(S_RUN));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
